onehot_encoder4_2: RTL and testbench

- Registered 4-to-2 encoder. It is the inverse of the team's 2-to-4 one-hot decoder: one-hot q=1000/0100/0010/0001 maps back to {a,b}=00/01/10/11.
- Sits on the return path. Turns one-hot select/grant vectors back into a 2-bit index.
- Valid/ready handshake on both sides, a one-entry output register, and detection of illegal (non-one-hot) patterns with a saturating error counter.

---
 rtl/onehot_encoder4_2.sv | 131 +++++++++++++
 tb/tb_onehot_encoder4_2.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder4_2.sv
`default_nettype none
// ============================================================================
// Module   : onehot_encoder4_2
// Purpose  : Registered 4-to-2 encoder for one-hot select/grant vectors on the
//            return path. Turns one-hot q_in back into a 2-bit index {a,b}
//            (q_in[3] -> 00 ... q_in[0] -> 11), with a valid/ready handshake on
//            both sides, a one-entry output register and a saturating counter
//            of accepted non-one-hot beats.
// Ports    : clk        rising-edge clock
//            rst        asynchronous reset, active-high
//            in_valid   q_in carries a beat
//            in_ready   block accepts a beat this cycle
//            q_in[3:0]  one-hot vector (q_in[3] = index 0)
//            out_valid  a/b/err hold a beat
//            out_ready  consumer accepts the beat this cycle
//            a, b       encoded index MSB, LSB
//            err        held beat came from a non-one-hot q_in
//            err_count  accepted illegal beats, saturating
//            clr_err    synchronous clear of err_count
// Revision : 1.0 - initial release
// ============================================================================
module onehot_encoder4_2 #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           q_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 a,
  output logic                 b,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clr_err
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [ERR_CNT_W-1:0] c_err_cnt_max = '1;

  state_t               state_q, state_d;
  logic                 a_q, a_d;
  logic                 b_q, b_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic                 w_accept;
  logic                 w_drain;
  logic [1:0]           w_enc_idx;
  logic                 w_enc_err;

  // Ready depends only on held state and the consumer, never on in_valid.
  assign in_ready  = (state_q == EMPTY) | out_ready;
  assign out_valid = (state_q == FULL);
  assign w_accept  = in_valid & in_ready;
  assign w_drain   = out_valid & out_ready;

  // Priority encode, MSB first; all-zero falls through to index 0.
  always_comb begin
    w_enc_idx = 2'b00;
    if (q_in[3])      w_enc_idx = 2'b00;
    else if (q_in[2]) w_enc_idx = 2'b01;
    else if (q_in[1]) w_enc_idx = 2'b10;
    else if (q_in[0]) w_enc_idx = 2'b11;
  end

  // Illegal whenever the vector is not exactly one-hot (zero or multi-hot).
  always_comb begin
    w_enc_err = 1'b1;
    case (q_in)
      4'b1000, 4'b0100, 4'b0010, 4'b0001: w_enc_err = 1'b0;
      default:                            w_enc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    err_d       = err_q;
    err_count_d = err_count_q;

    case (state_q)
      EMPTY:   if (w_accept) state_d = FULL;
      FULL:    if (w_drain && !w_accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    // Loading on every accept covers both EMPTY fill and FULL drain+refill.
    if (w_accept) begin
      a_d   = w_enc_idx[1];
      b_d   = w_enc_idx[0];
      err_d = w_enc_err;
    end

    // Clear has priority over a same-edge increment.
    if (clr_err) begin
      err_count_d = '0;
    end else if (w_accept && w_enc_err && (err_count_q != c_err_cnt_max)) begin
      err_count_d = err_count_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_onehot_encoder4_2.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_encoder4_2
// Purpose  : Self-checking bench for onehot_encoder4_2. Expected beats are
//            queued when stimulus is issued and popped by a monitor on drain.
//            A second instance with a 2-bit counter exercises saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_encoder4_2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] q_in = 4'b0000;
  logic       out_ready = 1'b0;
  logic       clr_err = 1'b0;

  logic       in_ready, out_valid, a, b, err;
  logic [7:0] err_count;
  logic       in_ready2, out_valid2, a2, b2, err2;
  logic [1:0] err_count2;

  int tests = 0;
  int fails = 0;

  logic [2:0] exp_q[$];     // {a,b,err} of accepted beats
  bit         model_full = 1'b0;
  int         cnt8 = 0;
  int         cnt2 = 0;

  always #5 clk = ~clk;

  onehot_encoder4_2 #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .q_in(q_in), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .err(err), .err_count(err_count), .clr_err(clr_err)
  );

  onehot_encoder4_2 #(.ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .q_in(q_in), .out_valid(out_valid2), .out_ready(out_ready),
    .a(a2), .b(b2), .err(err2), .err_count(err_count2), .clr_err(clr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: index is the position of the highest set bit counted from
  // the top (q[3] -> 0), zero vector -> 0; error when popcount is not 1.
  function automatic logic [2:0] ref_enc(input logic [3:0] q);
    int idx  = 0;
    int ones = 0;
    for (int i = 0; i < 4; i++) begin
      if (q[i]) begin
        ones++;
        idx = 3 - i;
      end
    end
    return {idx[1:0], (ones != 1)};
  endfunction

  // One clock of stimulus plus handshake/counter checks against the model.
  task automatic cycle(input bit v, input logic [3:0] q, input bit ordy, input bit clr);
    bit         acc;
    bit         drn;
    logic [2:0] e;
    @(posedge clk); #1;
    in_valid  = v;
    q_in      = q;
    out_ready = ordy;
    clr_err   = clr;
    acc = v && (!model_full || ordy);
    drn = model_full && ordy;
    e   = ref_enc(q);
    if (acc) exp_q.push_back(e);
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, model_full});
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!model_full || ordy)});
    chk("err_count", {24'd0, err_count}, cnt8);
    chk("err_count_w2", {30'd0, err_count2}, cnt2);
    if (clr) begin
      cnt8 = 0;
      cnt2 = 0;
    end else if (acc && e[0]) begin
      if (cnt8 < 255) cnt8++;
      if (cnt2 < 3)   cnt2++;
    end
    model_full = acc || (model_full && !drn);
  endtask

  // Monitor: whenever a beat is presented, it must match the oldest expected
  // beat; it is retired when the consumer takes it.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {29'd0, a, b, err}, 32'hFFFF_FFFF);
      end else begin
        chk("beat_abe", {29'd0, a, b, err}, {29'd0, exp_q[0]});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_abe", {29'd0, a, b, err}, 0);
    chk("rst_err_count", {24'd0, err_count}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Legal sweep back-to-back.
    cycle(1, 4'b1000, 1, 0);
    cycle(1, 4'b0100, 1, 0);
    cycle(1, 4'b0010, 1, 0);
    cycle(1, 4'b0001, 1, 0);
    cycle(0, 4'b0000, 1, 0);

    // Backpressure: hold 10 while 0001 waits, then drain and refill.
    cycle(1, 4'b0010, 1, 0);
    repeat (3) cycle(1, 4'b0001, 0, 0);
    cycle(1, 4'b0001, 1, 0);
    cycle(0, 4'b0000, 1, 0);

    // Illegal patterns.
    cycle(1, 4'b0000, 1, 0);
    cycle(1, 4'b0110, 1, 0);
    cycle(1, 4'b1111, 1, 0);
    cycle(0, 4'b0000, 1, 0);
    chk("illegal_count", {24'd0, err_count}, 3);

    // Saturation of the 2-bit counter, then clear beating an increment.
    repeat (5) cycle(1, 4'b1010, 1, 0);
    cycle(0, 4'b0000, 1, 0);
    chk("sat_w2", {30'd0, err_count2}, 3);
    chk("nosat_w8", {24'd0, err_count}, 8);
    cycle(1, 4'b0000, 1, 1);
    cycle(0, 4'b0000, 1, 0);
    chk("clr_w2", {30'd0, err_count2}, 0);
    chk("clr_w8", {24'd0, err_count}, 0);

    // Async reset while FULL and stalled.
    cycle(1, 4'b0011, 0, 0);
    cycle(0, 4'b0000, 0, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 0);
    chk("arst_abe", {29'd0, a, b, err}, 0);
    chk("arst_err_count", {24'd0, err_count}, 0);
    chk("arst_in_ready", {31'd0, in_ready}, 1);
    exp_q.delete();
    model_full = 1'b0;
    cnt8 = 0;
    cnt2 = 0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1, 4'b0100, 0, 0);
    cycle(0, 4'b0000, 1, 0);
    cycle(0, 4'b0000, 1, 0);

    // Randomized traffic with random backpressure and occasional clears.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), 4'($urandom),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 31) == 0));
    end
    cycle(0, 4'b0000, 1, 0);
    cycle(0, 4'b0000, 1, 0);
    chk("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
